// File: rtl/nps_inmem_pp.sv
// nps_inmem_pp: ping-pong input memory. The CPU fills one bank while the
// other bank streams a committed frame downstream through a two-stage
// read pipeline (RAM read register, then output register) that honours ri.
module nps_inmem_pp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADR_WIDTH  = 5,
    parameter int DEPTH      = 2**ADR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_x,
    input  logic [ADR_WIDTH-1:0]  cpu_adr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    input  logic                  cpu_wr,
    input  logic [ADR_WIDTH:0]    len,
    input  logic                  set,
    input  logic                  start,
    input  logic                  auto,
    input  logic                  ri,
    output logic                  vo,
    output logic                  fo,
    output logic [DATA_WIDTH-1:0] datao,
    output logic                  busy,
    output logic [1:0]            pend,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADR_WIDTH:0] LEN_MAX = (ADR_WIDTH+1)'(DEPTH);
    localparam logic [ADR_WIDTH:0] LEN_ONE = (ADR_WIDTH+1)'(1);

    // Both banks live in one array; the bank bit is the address MSB.
    logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_wbank;
    logic                  r_rbank;
    logic [ADR_WIDTH:0]    r_len0;
    logic [ADR_WIDTH:0]    r_len1;
    logic [1:0]            r_pend;
    logic [ADR_WIDTH:0]    r_rd_adr;
    logic                  r_s1_vld;
    logic                  r_s1_last;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_vo;
    logic                  r_fo;
    logic [DATA_WIDTH-1:0] r_datao;
    logic                  r_err;

    logic                  w_wr_ok;
    logic                  w_wr_err;
    logic                  w_set_ok;
    logic                  w_set_err;
    logic                  w_start_err;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_adv;
    logic                  w_last_rd;
    logic [ADR_WIDTH:0]    w_cur_len;

    // Command qualification: writes and commits need a free bank.
    assign w_wr_ok     = cpu_wr && (r_pend < 2'd2);
    assign w_wr_err    = cpu_wr && (r_pend == 2'd2);
    assign w_set_ok    = set && (r_pend < 2'd2) && (len != '0) && (len <= LEN_MAX);
    assign w_set_err   = set && !w_set_ok;
    assign w_start_err = start && !((r_state == S_IDLE) && (r_pend != 2'd0));

    // The pipeline moves as a whole when the output is empty or transferring.
    assign w_adv     = !r_vo || ri;
    assign w_cur_len = r_rbank ? r_len1 : r_len0;
    assign w_last_rd = (r_rd_adr == (w_cur_len - LEN_ONE));

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset_x) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next state and per-cycle strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((start || auto) && (r_pend != 2'd0)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_adv) begin
                    w_issue = 1'b1;
                    if (w_last_rd) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_vo && r_fo && ri) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bank pointers, frame lengths and pending-frame count.
    always_ff @(posedge clk) begin
        if (reset_x) begin
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_len0  <= '0;
            r_len1  <= '0;
            r_pend  <= 2'd0;
        end else begin
            if (w_set_ok) begin
                if (r_wbank) r_len1 <= len;
                else         r_len0 <= len;
                r_wbank <= ~r_wbank;
            end
            if (w_done) r_rbank <= ~r_rbank;
            r_pend <= r_pend + {1'b0, w_set_ok} - {1'b0, w_done};
        end
    end

    // RAM write port (fill bank).
    always_ff @(posedge clk) begin
        // NOTE: the RAM is deliberately not reset; contents survive reset_x
        // and a resettable array would not map onto block RAM.
        if (w_wr_ok) r_mem[{r_wbank, cpu_adr}] <= cpu_data;
    end

    // RAM read port (stream bank) feeding the first pipeline stage.
    always_ff @(posedge clk) begin
        if (w_issue) r_s1_data <= r_mem[{r_rbank, r_rd_adr[ADR_WIDTH-1:0]}];
    end

    // Read address counter and first-stage control.
    always_ff @(posedge clk) begin
        if (reset_x) begin
            r_rd_adr  <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
        end else begin
            if (w_accept)     r_rd_adr <= '0;
            else if (w_issue) r_rd_adr <= r_rd_adr + LEN_ONE;
            if (w_adv) begin
                r_s1_vld  <= w_issue;
                r_s1_last <= w_issue && w_last_rd;
            end
        end
    end

    // Output register: holds while vo is high and ri is low.
    always_ff @(posedge clk) begin
        if (reset_x) begin
            r_vo    <= 1'b0;
            r_fo    <= 1'b0;
            r_datao <= '0;
        end else if (w_adv) begin
            r_vo <= r_s1_vld;
            r_fo <= r_s1_vld && r_s1_last;
            if (r_s1_vld) r_datao <= r_s1_data;
        end
    end

    // Error pulse: all rejected commands of a cycle merge into one pulse.
    always_ff @(posedge clk) begin
        if (reset_x) r_err <= 1'b0;
        else         r_err <= w_wr_err || w_set_err || w_start_err;
    end

    assign vo    = r_vo;
    assign fo    = r_fo;
    assign datao = r_datao;
    assign busy  = (r_state != S_IDLE);
    assign pend  = r_pend;
    assign err   = r_err;

endmodule

// File: tb/tb_nps_inmem_pp.sv
// tb_nps_inmem_pp: randomized self-checking bench for nps_inmem_pp.
// The reference model tracks bank contents and turns each accepted commit
// into an ordered list of expected words; a monitor collects real transfers.
module tb_nps_inmem_pp;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk      = 1'b0;
    logic          reset_x  = 1'b1;
    logic [AW-1:0] cpu_adr  = '0;
    logic [DW-1:0] cpu_data = '0;
    logic          cpu_wr   = 1'b0;
    logic [AW:0]   len      = '0;
    logic          set      = 1'b0;
    logic          start    = 1'b0;
    logic          auto     = 1'b0;
    logic          ri       = 1'b0;
    logic          vo;
    logic          fo;
    logic [DW-1:0] datao;
    logic          busy;
    logic [1:0]    pend;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [DW-1:0] m_mem [2][DEPTH];
    int            m_wbank = 0;
    int            m_pend  = 0;
    logic [DW:0]   exp_q[$];
    logic [DW:0]   got_q[$];

    // Monitor state.
    int            hold_viol = 0;
    logic          held      = 1'b0;
    logic [DW-1:0] h_data    = '0;
    logic          h_fo      = 1'b0;

    always #5 clk = ~clk;

    nps_inmem_pp #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_x  (reset_x),
        .cpu_adr  (cpu_adr),
        .cpu_data (cpu_data),
        .cpu_wr   (cpu_wr),
        .len      (len),
        .set      (set),
        .start    (start),
        .auto     (auto),
        .ri       (ri),
        .vo       (vo),
        .fo       (fo),
        .datao    (datao),
        .busy     (busy),
        .pend     (pend),
        .err      (err)
    );

    // Collect transfers and flag any held word that changed before transfer.
    always @(negedge clk) begin
        if (reset_x) begin
            held = 1'b0;
        end else begin
            if (held && (vo !== 1'b1 || datao !== h_data || fo !== h_fo)) hold_viol++;
            if (vo === 1'b1 && ri === 1'b1) got_q.push_back({fo, datao});
            held   = (vo === 1'b1) && (ri === 1'b0);
            h_data = datao;
            h_fo   = fo;
        end
    end

    task automatic cpu_write(input int adr, input logic [DW-1:0] d);
        cpu_adr  = adr[AW-1:0];
        cpu_data = d;
        cpu_wr   = 1'b1;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        if (m_pend < 2) m_mem[m_wbank][adr] = d;
    endtask

    task automatic fill_frame(input int l, input logic [DW-1:0] base, input bit rnd);
        for (int i = 0; i < l; i++)
            cpu_write(i, rnd ? DW'($urandom) : base + DW'(i));
    endtask

    task automatic do_set(input int l);
        len = l[AW:0];
        set = 1'b1;
        @(posedge clk); #1;
        set = 1'b0;
        if (m_pend < 2 && l >= 1 && l <= DEPTH) begin
            for (int i = 0; i < l; i++)
                exp_q.push_back({1'(i == l - 1), m_mem[m_wbank][i]});
            m_wbank ^= 1;
            m_pend++;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive ri (0: always 1, 1: toggle 1,0,..., 2: random) until n words arrive.
    task automatic stream(input int n, input int mode, input int budget, input string name);
        int cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            case (mode)
                0:       ri = 1'b1;
                1:       ri = 1'((cyc % 2) == 0);
                default: ri = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        ri = 1'b0;
        n_checks++;
        if (got_q.size() != n)
            $display("FAIL %s_count: got %0d words, expected %0d", name, got_q.size(), n);
    endtask

    task automatic compare_got(input string name);
        logic [DW:0] g;
        logic [DW:0] e;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL %s_extra: got fo/data %0h, expected no word", name, g);
            end else begin
                e = exp_q.pop_front();
                if (e[DW]) m_pend--;
                if (g !== e) begin
                    n_errors++;
                    $display("FAIL %s_word: got fo/data %0h, expected %0h", name, g, e);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_missing: %0d words never arrived, expected 0", name, exp_q.size());
        end
        n_checks++;
        if (pend !== 2'(m_pend)) begin
            n_errors++;
            $display("FAIL %s_pend: got %0d, expected %0d", name, pend, m_pend);
        end
    endtask

    task automatic expect_err(input string name);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_err_hi: got %b, expected 1", name, err);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_err_lo: got %b, expected 0", name, err);
        end
    endtask

    task automatic test_reset();
        reset_x = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({vo, fo, busy, pend, err} !== 6'b0 || datao !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got vo%b fo%b busy%b pend%0d err%b data%0h, expected all 0",
                     vo, fo, busy, pend, err, datao);
        end
        @(posedge clk); #1;
        reset_x = 1'b0;
    endtask

    task automatic test_basic();
        fill_frame(30, 16'h1000, 1'b0);
        do_set(30);
        @(negedge clk);
        n_checks++;
        if (pend !== 2'd1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_set: got pend %0d err %b, expected 1 0", pend, err);
        end
        ri = 1'b1;
        do_start();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || vo !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_accept: got busy %b vo %b, expected 1 0", busy, vo);
        end
        @(negedge clk);
        n_checks++;
        if (vo !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_latency_early: got vo %b, expected 0", vo);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_checks++;
            if (vo !== 1'b1 || datao !== DW'(16'h1000 + i) || fo !== 1'(i == 29)) begin
                n_errors++;
                $display("FAIL basic_seq%0d: got vo%b fo%b %0h, expected vo1 fo%0d %0h",
                         i, vo, fo, datao, (i == 29), 16'h1000 + i);
            end
        end
        n_checks++;
        if (pend !== 2'd1) begin
            n_errors++;
            $display("FAIL basic_pend_before_fo: got %0d, expected 1", pend);
        end
        @(posedge clk); #1;
        ri = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pend !== 2'd0 || busy !== 1'b0 || vo !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_after_fo: got pend %0d busy %b vo %b, expected 0 0 0", pend, busy, vo);
        end
        compare_got("basic");
    endtask

    task automatic test_backpressure();
        int hv0;
        fill_frame(30, 16'h1000, 1'b0);
        do_set(30);
        hv0 = hold_viol;
        do_start();
        stream(30, 1, 200, "bp");
        compare_got("bp");
        n_checks++;
        if (hold_viol != hv0) begin
            n_errors++;
            $display("FAIL bp_hold: got %0d changed held words, expected 0", hold_viol - hv0);
        end
    endtask

    task automatic test_pingpong_auto();
        int cyc    = 0;
        int fo_cyc = -1;
        int vo_cyc = -1;
        auto = 1'b1;
        ri   = 1'b0;
        fill_frame(4, 16'h00A0, 1'b0);
        do_set(4);
        fill_frame(8, 16'h00B0, 1'b0);
        do_set(8);
        @(negedge clk);
        n_checks++;
        if (pend !== 2'd2) begin
            n_errors++;
            $display("FAIL pp_pend2: got %0d, expected 2", pend);
        end
        ri = 1'b1;
        while (vo_cyc < 0 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (fo_cyc < 0) begin
                if (vo === 1'b1 && fo === 1'b1 && datao === 16'h00A3) fo_cyc = cyc;
            end else if (vo === 1'b1) begin
                vo_cyc = cyc;
            end
        end
        n_checks++;
        if (fo_cyc < 0 || vo_cyc - fo_cyc - 1 != 3) begin
            n_errors++;
            $display("FAIL pp_gap_edges: got %0d edges from fo transfer to next vo, expected 3",
                     vo_cyc - fo_cyc - 1);
        end
        stream(12, 0, 100, "pp");
        auto = 1'b0;
        compare_got("pp");
    endtask

    task automatic test_overflow();
        fill_frame(3, '0, 1'b1);
        do_set(3);
        fill_frame(5, '0, 1'b1);
        do_set(5);
        do_set(4);
        expect_err("ovf_set");
        n_checks++;
        if (pend !== 2'd2) begin
            n_errors++;
            $display("FAIL ovf_pend: got %0d, expected 2", pend);
        end
        cpu_write(0, 16'hDEAD);
        expect_err("ovf_wr");
        do_start();
        stream(3, 2, 200, "ovf_a");
        do_start();
        stream(8, 2, 300, "ovf_b");
        compare_got("ovf");
    endtask

    task automatic test_len_bounds();
        do_set(0);
        expect_err("len0");
        n_checks++;
        if (pend !== 2'd0) begin
            n_errors++;
            $display("FAIL len0_pend: got %0d, expected 0", pend);
        end
        do_set(33);
        expect_err("len33");
        do_start();
        expect_err("start_empty");
        fill_frame(1, '0, 1'b1);
        do_set(1);
        ri = 1'b1;
        do_start();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({vo, fo} !== 2'b11) begin
            n_errors++;
            $display("FAIL len1_vo_fo: got %b%b, expected 11", vo, fo);
        end
        @(posedge clk); #1;
        ri = 1'b0;
        compare_got("len1");
        fill_frame(32, '0, 1'b1);
        do_set(32);
        do_start();
        stream(32, 2, 400, "len32");
        compare_got("len32");
    endtask

    task automatic test_random();
        int l;
        for (int k = 0; k < 4; k++) begin
            l = $urandom_range(1, DEPTH);
            fill_frame(l, '0, 1'b1);
            do_set(l);
            do_start();
            stream(l, 2, 400, "rnd");
            compare_got("rnd");
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        logic [DW:0] g;
        logic [DW:0] e;
        fill_frame(30, '0, 1'b1);
        do_set(30);
        ri = 1'b1;
        do_start();
        while (got_q.size() < 10 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        reset_x = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({vo, fo, busy, pend, err} !== 6'b0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs: got vo%b fo%b busy%b pend%0d err%b, expected all 0",
                     vo, fo, busy, pend, err);
        end
        ri      = 1'b0;
        reset_x = 1'b0;
        n_checks++;
        if (got_q.size() != 10) begin
            n_errors++;
            $display("FAIL rst_mid_count: got %0d words, expected 10", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL rst_mid_word: got %0h, expected %0h", g, e);
            end
        end
        got_q.delete();
        exp_q.delete();
        m_pend  = 0;
        m_wbank = 0;
        do_start();
        expect_err("rst_start");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_pingpong_auto();
        test_overflow();
        test_len_bounds();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
